// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOT = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_LSL = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: every op except MUL, which is sequenced by alu_seq.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned SH = $clog2(WIDTH);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // The extra bit of an unsigned subtraction is the borrow, i.e. a < b.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_NOT:  result = ~a;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LSL:  result = a << b[SH-1:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops finish in one cycle, MUL runs a WIDTH-step
// shift-add loop into a 2*WIDTH accumulator.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, next_state;

  logic [WIDTH-1:0]   c_result;
  logic               c_carry;
  logic               c_ovf;

  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a      (a),
    .b      (b),
    .op     (op),
    .result (c_result),
    .carry  (c_carry),
    .ovf    (c_ovf)
  );

  // One partial product per cycle: multiplier shifts right, multiplicand left.
  assign acc_next = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = (op == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:   if (cnt == LAST) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      mplier <= '0;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              result <= c_result;
              carry  <= c_carry;
              ovf    <= c_ovf;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= acc_next[WIDTH-1:0];
            carry  <= |acc_next[2*WIDTH-1:WIDTH];
            ovf    <= |acc_next[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign zero = (result == '0);
  assign neg  = result[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 and WIDTH=16 with hand-computed results.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       start8 = 1'b0;
  op_t        op8    = OP_ADD;
  logic [7:0] a8     = '0;
  logic [7:0] b8     = '0;
  logic       busy8, done8, zero8, neg8, carry8, ovf8;
  logic [7:0] result8;

  logic        start16 = 1'b0;
  op_t         op16    = OP_ADD;
  logic [15:0] a16     = '0;
  logic [15:0] b16     = '0;
  logic        busy16, done16, zero16, neg16, carry16, ovf16;
  logic [15:0] result16;

  int vectors    = 0;
  int miscompares = 0;
  int cyc;
  int pulses;
  logic busy_ok;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .zero(zero8),
    .neg(neg8), .carry(carry8), .ovf(ovf8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .zero(zero16),
    .neg(neg16), .carry(carry16), .ovf(ovf16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue8(input op_t o, input logic [7:0] x, input logic [7:0] y);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  task automatic flags8(input string tag, input logic [7:0] r, input logic z, input logic n,
                        input logic c, input logic v);
    check({tag, "_done"},   {31'd0, done8},  32'd1);
    check({tag, "_result"}, {24'd0, result8}, {24'd0, r});
    check({tag, "_zero"},   {31'd0, zero8},  {31'd0, z});
    check({tag, "_neg"},    {31'd0, neg8},   {31'd0, n});
    check({tag, "_carry"},  {31'd0, carry8}, {31'd0, c});
    check({tag, "_ovf"},    {31'd0, ovf8},   {31'd0, v});
  endtask

  task automatic run8(input string tag, input op_t o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] r, input logic z, input logic n, input logic c, input logic v);
    issue8(o, x, y);
    flags8(tag, r, z, n, c, v);
    tick();
    check({tag, "_done_drop"}, {31'd0, done8}, 32'd0);
    check({tag, "_hold"},      {24'd0, result8}, {24'd0, r});
  endtask

  task automatic wait_done8(output int n);
    n = 1;
    while (done8 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run16(input string tag, input op_t o, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] r, input logic z, input logic n, input logic c,
                       input int lat);
    int k;
    op16 = o; a16 = x; b16 = y; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    k = 1;
    while (done16 !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, k,                 lat);
    check({tag, "_result"},  {16'd0, result16}, {16'd0, r});
    check({tag, "_zero"},    {31'd0, zero16},   {31'd0, z});
    check({tag, "_neg"},     {31'd0, neg16},    {31'd0, n});
    check({tag, "_carry"},   {31'd0, carry16},  {31'd0, c});
    tick();
  endtask

  initial begin
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_busy",   {31'd0, busy8},   32'd0);
    check("rst_done",   {31'd0, done8},   32'd0);
    check("rst_result", {24'd0, result8}, 32'd0);
    check("rst_zero",   {31'd0, zero8},   32'd1);
    check("rst_neg",    {31'd0, neg8},    32'd0);
    check("rst_carry",  {31'd0, carry8},  32'd0);
    check("rst_ovf",    {31'd0, ovf8},    32'd0);
    rst = 1'b0;

    run8("add_100_100", OP_ADD, 8'd100, 8'd200 - 8'd100, 8'hC8, 1'b0, 1'b1, 1'b0, 1'b1);
    run8("sub_50_200",  OP_SUB, 8'd50,  8'd200, 8'd106, 1'b0, 1'b0, 1'b1, 1'b0);
    run8("sub_50_50",   OP_SUB, 8'd50,  8'd50,  8'd0,   1'b1, 1'b0, 1'b0, 1'b0);
    run8("add_carry",   OP_ADD, 8'd200, 8'd100, 8'h2C,  1'b0, 1'b0, 1'b1, 1'b0);
    run8("and",         OP_AND, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0, 1'b0, 1'b0);
    run8("or",          OP_OR,  8'hF0,  8'h0C,  8'hFC,  1'b0, 1'b1, 1'b0, 1'b0);
    run8("not",         OP_NOT, 8'h0F,  8'hAA,  8'hF0,  1'b0, 1'b1, 1'b0, 1'b0);
    run8("lsl_0",       OP_LSL, 8'h81,  8'h00,  8'h81,  1'b0, 1'b1, 1'b0, 1'b0);
    run8("lsl_mask",    OP_LSL, 8'h81,  8'h09,  8'h02,  1'b0, 1'b0, 1'b0, 1'b0);

    issue8(OP_MUL, 8'd12, 8'd11);
    check("mul12_busy", {31'd0, busy8}, 32'd1);
    wait_done8(cyc);
    check("mul12_latency", cyc, 9);
    flags8("mul12", 8'h84, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    issue8(OP_MUL, 8'd20, 8'd20);
    wait_done8(cyc);
    check("mul20_latency", cyc, 9);
    flags8("mul20", 8'h90, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();

    // start held with fresh operands during a multiply must change nothing
    issue8(OP_MUL, 8'd3, 8'd5);
    start8 = 1'b1; op8 = OP_ADD; a8 = 8'd200; b8 = 8'd200;
    busy_ok = 1'b1;
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 40) begin
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    start8 = 1'b0;
    check("mulhold_busy",    {31'd0, busy_ok}, 32'd1);
    check("mulhold_latency", cyc, 9);
    flags8("mulhold", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    repeat (4) begin
      tick();
      if (done8 === 1'b1) pulses++;
    end
    check("mulhold_extra_done", pulses, 0);

    // start during the DONE cycle is dropped
    issue8(OP_ADD, 8'd1, 8'd1);
    check("done_start_first", {24'd0, result8}, 32'd2);
    start8 = 1'b1; op8 = OP_SUB; a8 = 8'd5; b8 = 8'd1;
    tick();
    start8 = 1'b0;
    check("done_start_busy", {31'd0, busy8}, 32'd0);
    tick();
    check("done_start_ignored_busy", {31'd0, busy8},   32'd0);
    check("done_start_result",       {24'd0, result8}, 32'd2);

    // asynchronous reset four cycles into a multiply
    issue8(OP_MUL, 8'd15, 8'd15);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("abort_busy",   {31'd0, busy8},   32'd0);
    check("abort_done",   {31'd0, done8},   32'd0);
    check("abort_result", {24'd0, result8}, 32'd0);
    check("abort_zero",   {31'd0, zero8},   32'd1);
    check("abort_carry",  {31'd0, carry8},  32'd0);
    tick();
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      tick();
      if (done8 === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run8("add_after_abort", OP_ADD, 8'd1, 8'd3, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);

    run16("w16_not", OP_NOT, 16'h0012, 16'hABCD, 16'hFFED, 1'b0, 1'b1, 1'b0, 1);
    run16("w16_lsl", OP_LSL, 16'h0001, 16'd15,   16'h8000, 1'b0, 1'b1, 1'b0, 1);
    run16("w16_xor", OP_XOR, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1);
    run16("w16_mul", OP_MUL, 16'd300,  16'd300,  16'h5F90, 1'b0, 1'b0, 1'b1, 17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL be >= 4 and a power of two.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset; asynchronous and active-high.
REQ-004 Port start  input  1  request; sampled only in IDLE.
REQ-005 Port op  input  3  operation code, alu_pkg::op_t.
REQ-006 Port a  input  WIDTH  operand A, two's complement.
REQ-007 Port b  input  WIDTH  operand B, two's complement.
REQ-008 Port busy  output  1  high whenever state != IDLE.
REQ-009 Port done  output  1  one-cycle pulse when result and flags become valid.
REQ-010 Port result  output  WIDTH  registered result.
REQ-011 Port zero  output  1  result == 0.
REQ-012 Port neg  output  1  result[WIDTH-1].
REQ-013 Port carry  output  1  unsigned carry/borrow/overflow, per REQ-019.
REQ-014 Port ovf  output  1  signed overflow, per REQ-019.

Function
REQ-015 Op codes: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 NOT a (b ignored); 100 OR; 101 XOR; 110 LSL a by b[log2(WIDTH)-1:0]; 111 MUL, unsigned, low WIDTH bits.
REQ-016 States IDLE, MUL, DONE; IDLE+start+op!=MUL -> DONE; IDLE+start+op==MUL -> MUL; MUL after WIDTH iterations -> DONE; DONE -> IDLE unconditionally.
REQ-017 Non-MUL ops: a, b, op captured and result/flags registered on the accepting edge; done high in the following cycle (latency 1).
REQ-018 MUL: shift-add, one partial-product bit per cycle, 2*WIDTH-bit accumulator; done high WIDTH+1 cycles after the accepting edge.
REQ-019 Flags: ADD carry = carry-out, ovf = signed overflow; SUB carry = borrow (a < b unsigned), ovf = signed overflow; MUL carry = ovf = (upper WIDTH bits of product != 0); logic ops and LSL carry = ovf = 0.
REQ-020 zero and neg derive from the registered result for every op.
REQ-021 start while busy is ignored; a and b may change freely after acceptance without affecting the running op.
REQ-022 done high for exactly one cycle, only in DONE; result and flags hold their values until the next accepted op finishes.
REQ-023 start asserted in the DONE cycle is ignored; a new op is accepted no earlier than the following IDLE cycle.
REQ-024 Arithmetic wraps modulo 2^WIDTH; no saturation.
REQ-025 LSL by 0 returns a unchanged.

Reset
REQ-026 rst asserted: state = IDLE, busy = done = 0, result = 0, zero = 1, neg = carry = ovf = 0, MUL accumulator and counter cleared.
REQ-027 rst mid-MUL aborts the op; no done pulse is produced for it.
REQ-028 First op is accepted on the first rising edge with rst low and start high.

Structure
REQ-029 Package alu_pkg SHALL hold op_t (3-bit enum), state_t (IDLE/MUL/DONE) and the op-code constants.
REQ-030 Single-cycle datapath SHALL be sub-module alu_comb (a, b, op -> result, carry, ovf), parametrised by WIDTH; MUL sequencing lives in alu_seq.

Verification
REQ-031 WIDTH=8, ADD 100+100 -> one cycle later done=1, result=200 (0xC8), neg=1, zero=0, carry=0, ovf=1.
REQ-032 SUB 50-200 -> result=106, carry=1, ovf=0; SUB 50-50 -> result=0, zero=1, carry=0.
REQ-033 MUL 12*11 -> done exactly 9 cycles after acceptance, result=0x84, carry=ovf=0; MUL 20*20 -> result=0x90, carry=ovf=1.
REQ-034 start held high with new operands during MUL -> busy=1, operands ignored, single done pulse, original product returned.
REQ-035 rst asserted 4 cycles into MUL -> outputs take reset values immediately, no done pulse; next ADD 1+3 returns 4 normally.
REQ-036 WIDTH=16 regression: NOT 0x0012 -> 0xFFED, neg=1; LSL 0x0001 by 15 -> 0x8000; XOR 0xFFFF,0xFFFF -> 0, zero=1.
